systolic_array_ctrl: RTL and testbench

Sequencer for the 2x2 weight-stationary `systolic_array`: accepts a job command (four weights plus a vector count), pulses the array's weight load, streams input vectors into it with the required row skew, and deskews the results. Results are returned on a valid/ready stream through a credit-protected result FIFO, so the free-running array never has to stall. Sits between the host/DMA stream interfaces and one `systolic_array` instance.

---
 rtl/sa_ctrl_pkg.sv | 16 +
 rtl/sa_result_fifo.sv | 60 ++++++
 rtl/systolic_array_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_systolic_array_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_ctrl_pkg.sv
// Shared types and constants for the 2x2 systolic array sequencer.
// Latency: none (package only).
// Backpressure: none (package only).
package sa_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } sa_ctrl_state_e;

    // Cycles from vector accept to the aligned result pair being pushed.
    localparam int SA_LATENCY = 4;

endpackage

// File: rtl/sa_result_fifo.sv
// Synchronous result FIFO; pop_data shows the head entry (zero when empty).
// Latency: a push is visible at the head on the following cycle.
// Backpressure: push while full is dropped; pop while empty is ignored.
module sa_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    // Gate the head with empty so the output reads zero out of reset.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // The controller's credit scheme must never let the FIFO overflow.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset_n) !(push && full));

endmodule

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for a 2x2 weight-stationary array: weight load, skewed issue, deskewed results.
// Latency: vector accepted at cycle t is pushed at t+4, out_valid at t+5 at the earliest.
// Backpressure: in_ready is withheld unless in-flight plus queued results fit the FIFO (macro SA_CTRL_PERF_EN adds a stall counter).
module systolic_array_ctrl
    import sa_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_w00,
    input  logic [DATA_WIDTH-1:0] cmd_w01,
    input  logic [DATA_WIDTH-1:0] cmd_w10,
    input  logic [DATA_WIDTH-1:0] cmd_w11,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_x0,
    input  logic [DATA_WIDTH-1:0] in_x1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_y0,
    output logic [DATA_WIDTH-1:0] out_y1,
    output logic                  busy,
    output logic                  done,
`ifdef SA_CTRL_PERF_EN
    output logic [31:0]           perf_stall_cycles,
`endif
    output logic                  sa_load_weights,
    output logic                  sa_start,
    output logic [DATA_WIDTH-1:0] sa_w00,
    output logic [DATA_WIDTH-1:0] sa_w01,
    output logic [DATA_WIDTH-1:0] sa_w10,
    output logic [DATA_WIDTH-1:0] sa_w11,
    output logic [DATA_WIDTH-1:0] sa_x0,
    output logic [DATA_WIDTH-1:0] sa_x1,
    input  logic [DATA_WIDTH-1:0] sa_y0,
    input  logic [DATA_WIDTH-1:0] sa_y1
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW  = $clog2(SA_LATENCY + 1);
    localparam int CW  = $clog2(FIFO_DEPTH + SA_LATENCY + 1);

    sa_ctrl_state_e state;
    sa_ctrl_state_e state_nxt;

    logic [DATA_WIDTH-1:0] w00_q, w01_q, w10_q, w11_q;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [SA_LATENCY-1:0] vld_sr;
    logic [DATA_WIDTH-1:0] x1_q;
    logic [DATA_WIDTH-1:0] y0_q;
    logic [FCW-1:0]        fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [IW-1:0]         inflight;
    logic [CW-1:0]         used_credits;
    logic                  credit_ok;
    logic                  cmd_fire;
    logic                  in_fire;
    logic                  out_fire;
    logic                  drain_done;
    logic                  done_q;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Results still travelling through the array, counted from the valid shift register.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < SA_LATENCY; i++) begin
            inflight = inflight + IW'(vld_sr[i]);
        end
    end

    // Credits are taken from registered counts, so a same-cycle pop frees nothing yet.
    assign used_credits = CW'(inflight) + CW'(fifo_count);
    assign credit_ok    = (used_credits < CW'(FIFO_DEPTH));

    // Next-state and control decode.
    always_comb begin
        state_nxt       = state;
        cmd_ready       = 1'b0;
        in_ready        = 1'b0;
        sa_load_weights = 1'b0;
        sa_start        = 1'b0;
        busy            = 1'b1;
        drain_done      = 1'b0;
        unique case (state)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = LOAD;
            end
            LOAD: begin
                sa_load_weights = 1'b1;
                state_nxt       = (remaining == '0) ? DRAIN : RUN;
            end
            RUN: begin
                sa_start = 1'b1;
                in_ready = (remaining != '0) && credit_ok;
                if (in_valid && in_ready && remaining == LEN_WIDTH'(1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                sa_start = |vld_sr;
                if (!(|vld_sr) && fifo_empty) begin
                    drain_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Job registers: weights and remaining vector count latched on command accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w00_q     <= '0;
            w01_q     <= '0;
            w10_q     <= '0;
            w11_q     <= '0;
            remaining <= '0;
        end else if (cmd_fire) begin
            w00_q     <= cmd_w00;
            w01_q     <= cmd_w01;
            w10_q     <= cmd_w10;
            w11_q     <= cmd_w11;
            remaining <= cmd_len;
        end else if (in_fire) begin
            remaining <= remaining - LEN_WIDTH'(1);
        end
    end

    // Row skew on input, column deskew on output, and the valid tag that follows each vector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_sr <= '0;
            x1_q   <= '0;
            y0_q   <= '0;
        end else begin
            vld_sr <= {vld_sr[SA_LATENCY-2:0], in_fire};
            x1_q   <= in_fire ? in_x1 : '0;
            y0_q   <= sa_y0;
        end
    end

    // Completion pulse lands one cycle after the drain condition is seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) done_q <= 1'b0;
        else          done_q <= drain_done;
    end

`ifdef SA_CTRL_PERF_EN
    // Saturating count of RUN cycles with work pending but no vector accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cycles <= '0;
        end else if (cmd_fire) begin
            perf_stall_cycles <= '0;
        end else if (state == RUN && remaining != '0 && !in_fire && perf_stall_cycles != '1) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

    assign done   = done_q;
    assign sa_w00 = w00_q;
    assign sa_w01 = w01_q;
    assign sa_w10 = w10_q;
    assign sa_w11 = w11_q;
    // Bubbles are injected as zeros so idle slots carry no stale operands.
    assign sa_x0  = in_fire ? in_x0 : '0;
    assign sa_x1  = x1_q;

    sa_result_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (vld_sr[SA_LATENCY-1]),
        .push_data ({y0_q, sa_y1}),
        .pop       (out_fire),
        .pop_data  ({out_y0, out_y1}),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Scoreboard bench for systolic_array_ctrl with a behavioural 2x2 array attached.
// Array timing: input registers, y0 valid 3 cycles and y1 4 cycles after sa_x0 is driven.
// Expected results pushed at issue; a forked monitor pops and compares on every out handshake.
module tb_systolic_array_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_w00, cmd_w01, cmd_w10, cmd_w11, cmd_len;
    logic       in_valid, in_ready;
    logic [7:0] in_x0, in_x1;
    logic       out_valid, out_ready;
    logic [7:0] out_y0, out_y1;
    logic       busy, done, sa_load_weights, sa_start;
    logic [7:0] sa_w00, sa_w01, sa_w10, sa_w11, sa_x0, sa_x1, sa_y0, sa_y1;
`ifdef SA_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    systolic_array_ctrl #(.DATA_WIDTH(8), .LEN_WIDTH(8), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_w00(cmd_w00), .cmd_w01(cmd_w01), .cmd_w10(cmd_w10), .cmd_w11(cmd_w11),
        .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_x0(in_x0), .in_x1(in_x1),
        .out_valid(out_valid), .out_ready(out_ready), .out_y0(out_y0), .out_y1(out_y1),
        .busy(busy), .done(done),
`ifdef SA_CTRL_PERF_EN
        .perf_stall_cycles(perf_stall_cycles),
`endif
        .sa_load_weights(sa_load_weights), .sa_start(sa_start),
        .sa_w00(sa_w00), .sa_w01(sa_w01), .sa_w10(sa_w10), .sa_w11(sa_w11),
        .sa_x0(sa_x0), .sa_x1(sa_x1), .sa_y0(sa_y0), .sa_y1(sa_y1)
    );

    // Behavioural weight-stationary array: y0 = x0*w00 + x1*w10, y1 = x0*w01 + x1*w11.
    logic [7:0] aw00, aw01, aw10, aw11, xr0, xr1, p00, a01, p01, b11, ay0, ay1;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aw00 <= 0; aw01 <= 0; aw10 <= 0; aw11 <= 0;
            xr0 <= 0; xr1 <= 0; p00 <= 0; a01 <= 0; p01 <= 0; b11 <= 0; ay0 <= 0; ay1 <= 0;
        end else begin
            if (sa_load_weights) begin
                aw00 <= sa_w00; aw01 <= sa_w01; aw10 <= sa_w10; aw11 <= sa_w11;
            end
            xr0 <= sa_x0;
            xr1 <= sa_x1;
            p00 <= xr0 * aw00;
            a01 <= xr0;
            ay0 <= p00 + xr1 * aw10;
            b11 <= xr1;
            p01 <= a01 * aw01;
            ay1 <= p01 + b11 * aw11;
        end
    end
    assign sa_y0 = ay0;
    assign sa_y1 = ay1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    int          pop_cycles[$];
    int          acc_cycles[$];
    int          acc_cnt = 0, done_cnt = 0, load_cnt = 0, ovalid_cnt = 0;
    int          load_cyc = 0, cmd_cyc = 0, w_done_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (in_valid && in_ready) acc_cnt++;
                if (done) done_cnt++;
                if (sa_load_weights) begin load_cnt++; load_cyc = cyc; end
                if (out_valid) ovalid_cnt++;
                if (out_valid && out_ready) begin
                    pop_cycles.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_result: got (%0d,%0d) expected none", out_y0, out_y1);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {16'd0, out_y0, out_y1}, {16'd0, e});
                    end
                end
            end
        end
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic send_cmd(input logic [7:0] a, b, c, d, len);
        int n = 0;
        cmd_valid = 1; cmd_w00 = a; cmd_w01 = b; cmd_w10 = c; cmd_w11 = d; cmd_len = len;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        check("cmd_accept", cmd_ready, 1);
        cmd_cyc = cyc;
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic send_vec(input logic [7:0] x0, x1, e0, e1);
        int n = 0;
        in_valid = 1; in_x0 = x0; in_x1 = x1;
        exp_q.push_back({e0, e1});
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) check("in_accept_timeout", in_ready, 1);
        acc_cycles.push_back(cyc);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        @(negedge clk);
        while (!done && n < 300) begin @(negedge clk); n++; end
        check({name, "_done"}, done, 1);
        w_done_cyc = cyc;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, lbase, vbase, dbase;
        cmd_valid = 0; cmd_w00 = 0; cmd_w01 = 0; cmd_w10 = 0; cmd_w11 = 0; cmd_len = 0;
        in_valid = 0; in_x0 = 0; in_x1 = 0; out_ready = 1;
        fork monitor(); join_none

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sa_ctrl", {sa_load_weights, sa_start}, 0);
        check("rst_data", {out_y0, out_y1, sa_w00, sa_w11}, 0);
        check("rst_sa_x", {sa_x0, sa_x1}, 0);
        @(posedge clk); #1 reset_n = 1;
        @(posedge clk); #1;

        // Single vector: 5*1+6*3=23, 5*2+6*4=34
        pop_cycles.delete(); acc_cycles.delete();
        send_cmd(1, 2, 3, 4, 1);
        send_vec(5, 6, 23, 34);
        wait_done("t1");
        check("t1_pops", pop_cycles.size(), 1);
        if (pop_cycles.size() == 1) begin
            check("t1_latency", pop_cycles[0] - acc_cycles[0], 5);
            check("t1_done_after_pop", w_done_cyc - pop_cycles[0], 2);
        end
        check("t1_idle", {busy, cmd_ready}, 2'b01);

        // Four back-to-back vectors
        pop_cycles.delete(); acc_cycles.delete();
        send_cmd(1, 2, 3, 4, 4);
        send_vec(1, 1, 4, 6);
        send_vec(2, 2, 8, 12);
        send_vec(3, 3, 12, 18);
        send_vec(4, 4, 16, 24);
        wait_done("t2");
        check("t2_pops", pop_cycles.size(), 4);
        if (pop_cycles.size() == 4 && acc_cycles.size() == 4) begin
            check("t2_acc_span", acc_cycles[3] - acc_cycles[0], 3);
            check("t2_pop_span", pop_cycles[3] - pop_cycles[0], 3);
            check("t2_latency", pop_cycles[0] - acc_cycles[0], 5);
        end

        // Credit limit with out_ready low: x=(i,i+1) -> (4i+3, 6i+4)
        pop_cycles.delete(); acc_cycles.delete();
        out_ready = 0;
        send_cmd(1, 2, 3, 4, 10);
        base = acc_cnt;
        fork
            begin
                for (int i = 1; i <= 10; i++)
                    send_vec(8'(i), 8'(i + 1), 8'(4 * i + 3), 8'(6 * i + 4));
            end
            begin
                repeat (20) @(negedge clk);
                check("t3_accepts_at_full", acc_cnt - base, 8);
                check("t3_in_ready_low", in_ready, 0);
                check("t3_run_ctrl", {busy, sa_start}, 2'b11);
                check("t3_head", {out_valid, out_y0, out_y1}, {1'b1, 8'd7, 8'd10});
                @(negedge clk);
                check("t3_head_hold", {out_valid, out_y0, out_y1}, {1'b1, 8'd7, 8'd10});
                @(posedge clk); #1 out_ready = 1;
            end
        join
        wait_done("t3");
        check("t3_pops", pop_cycles.size(), 10);
        if (pop_cycles.size() == 10)
            check("t3_done_after_pop", w_done_cyc - pop_cycles[9], 2);

        // Wrap: 255*255*2 mod 256 = 2
        send_cmd(255, 255, 255, 255, 1);
        send_vec(255, 255, 2, 2);
        wait_done("t4");

        // Zero-length job
        lbase = load_cnt; vbase = ovalid_cnt;
        send_cmd(9, 8, 7, 6, 0);
        wait_done("t5");
        check("t5_load_pulses", load_cnt - lbase, 1);
        check("t5_load_cycle", load_cyc - cmd_cyc, 1);
        check("t5_done_cycle", w_done_cyc - cmd_cyc, 3);
        check("t5_no_out_valid", ovalid_cnt - vbase, 0);
        check("t5_weights_held", {sa_w00, sa_w11}, {8'd9, 8'd6});

        // Reset mid-RUN with three results queued
        out_ready = 0;
        send_cmd(1, 2, 3, 4, 10);
        send_vec(1, 1, 4, 6);
        send_vec(2, 2, 8, 12);
        send_vec(3, 3, 12, 18);
        repeat (8) @(negedge clk);
        check("t6_queued", {out_valid, out_y0, out_y1}, {1'b1, 8'd4, 8'd6});
        dbase = done_cnt;
        #1 reset_n = 0;
        #1;
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_idle", {cmd_ready, busy, in_ready}, 3'b100);
        exp_q.delete();
        @(posedge clk); #1 reset_n = 1;
        vbase = ovalid_cnt;
        repeat (5) @(negedge clk);
        check("t6_fifo_empty", ovalid_cnt - vbase, 0);
        check("t6_no_done", done_cnt - dbase, 0);
        @(posedge clk); #1;

        // Fresh job after reset: (1,2)->(12,17), (3,1)->(11,16)
        out_ready = 1;
        pop_cycles.delete();
        send_cmd(2, 3, 5, 7, 2);
        send_vec(1, 2, 12, 17);
        send_vec(3, 1, 11, 16);
        wait_done("t7");
        check("t7_pops", pop_cycles.size(), 2);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
